// File: rtl/sram_req_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_req_arbiter_if                                        |
// | Description : Bundle of every handshake/data signal around the SRAM      |
// |               request arbiter: two master address/data channels and the  |
// |               shared memory-controller port.                             |
// |   slave  modport : the arbiter's view (drives *_o, samples *_i)          |
// |   master modport : the surrounding world (masters + controller)          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface sram_req_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  // master 0 / master 1 address channels
  logic                  req0_addr_valid_i;
  logic                  req1_addr_valid_i;
  logic                  req0_addr_ready_o;
  logic                  req1_addr_ready_o;
  logic [ADDR_WIDTH-1:0] req0_addr_i;
  logic [ADDR_WIDTH-1:0] req1_addr_i;
  // master 0 / master 1 read-data channels
  logic                  req0_data_valid_o;
  logic                  req1_data_valid_o;
  logic                  req0_data_ready_i;
  logic                  req1_data_ready_i;
  logic [DATA_WIDTH-1:0] req0_data_o;
  logic [DATA_WIDTH-1:0] req1_data_o;
  // controller port
  logic                  mc_addr_valid_o;
  logic                  mc_addr_ready_i;
  logic [ADDR_WIDTH-1:0] mc_addr_o;
  logic                  mc_data_valid_i;
  logic                  mc_data_ready_o;
  logic [DATA_WIDTH-1:0] mc_data_i;
  // status
  logic                  err_o;

  modport slave (
    input  req0_addr_valid_i, req1_addr_valid_i, req0_addr_i, req1_addr_i,
    input  req0_data_ready_i, req1_data_ready_i,
    input  mc_addr_ready_i, mc_data_valid_i, mc_data_i,
    output req0_addr_ready_o, req1_addr_ready_o,
    output req0_data_valid_o, req1_data_valid_o, req0_data_o, req1_data_o,
    output mc_addr_valid_o, mc_addr_o, mc_data_ready_o, err_o
  );

  modport master (
    output req0_addr_valid_i, req1_addr_valid_i, req0_addr_i, req1_addr_i,
    output req0_data_ready_i, req1_data_ready_i,
    output mc_addr_ready_i, mc_data_valid_i, mc_data_i,
    input  req0_addr_ready_o, req1_addr_ready_o,
    input  req0_data_valid_o, req1_data_valid_o, req0_data_o, req1_data_o,
    input  mc_addr_valid_o, mc_addr_o, mc_data_ready_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_req_arbiter                                           |
// | Description : Shares one SRAM controller read port between two masters.  |
// |               Addresses are arbitrated (round-robin on ties), registered |
// |               onto the controller address channel and the grantee id is  |
// |               queued in a tag FIFO. Read data comes back in issue order  |
// |               and is steered combinationally to the owning master.       |
// | Ports       : clk   - clock, rising edge                                 |
// |               rst_n - asynchronous active-low reset                      |
// |               bus   - sram_req_arbiter_if.slave (masters + controller)   |
// | Config      : ARB_FIXED_PRIORITY_EN - port 0 always wins a tie           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sram_req_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4    // max outstanding reads, power of two >= 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  sram_req_arbiter_if.slave bus
);

  localparam int c_ptr_w = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(TAG_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,   // output register empty
    ST_ISSUE = 1'b1    // mc_addr_o holds an address awaiting mc_addr_ready_i
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_mc_addr_valid;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [TAG_DEPTH-1:0]  r_tags;     // one owner bit per outstanding read
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic                  r_err;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_can_accept;
  logic                  w_winner;
  logic                  w_winner_valid;
  logic [ADDR_WIDTH-1:0] w_winner_addr;
  logic                  w_accept;
  logic                  w_head;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_rdata;

  // ---------------------------------------------------------------- arbitration
  assign w_fifo_full  = (r_count == c_full_count);
  assign w_fifo_empty = (r_count == '0);

  // The output register can be reloaded when empty, or in the same cycle the
  // controller takes its current content (back-to-back issue).
  assign w_can_accept = !w_fifo_full && ((r_state == ST_IDLE) || bus.mc_addr_ready_i);

`ifdef ARB_FIXED_PRIORITY_EN
  assign w_winner = !bus.req0_addr_valid_i;
`else
  logic r_last_grant;

  // On a tie the port that did not win last time is served.
  assign w_winner = (bus.req0_addr_valid_i && bus.req1_addr_valid_i) ? !r_last_grant
                                                                     : !bus.req0_addr_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;   // makes port 0 win the first tie
    end else if (w_accept) begin
      r_last_grant <= w_winner;
    end
  end
`endif

  assign w_winner_valid = w_winner ? bus.req1_addr_valid_i : bus.req0_addr_valid_i;
  assign w_winner_addr  = w_winner ? bus.req1_addr_i       : bus.req0_addr_i;
  assign w_accept       = w_can_accept && w_winner_valid;

  assign bus.req0_addr_ready_o = w_can_accept && !w_winner && bus.req0_addr_valid_i;
  assign bus.req1_addr_ready_o = w_can_accept &&  w_winner && bus.req1_addr_valid_i;

  // ------------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mc_addr_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_mc_addr_valid = 1'b1;
        if (bus.mc_addr_ready_i && !w_accept) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address register only loads on an upstream handshake, so it stays stable
  // for as long as the controller back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= w_winner_addr;
    end
  end

  assign bus.mc_addr_valid_o = w_mc_addr_valid;
  assign bus.mc_addr_o       = r_addr;

  // ------------------------------------------------------------------ tag FIFO
  assign w_head = r_tags[r_rd_ptr];
  assign w_pop  = bus.mc_data_valid_i && bus.mc_data_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tags   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_tags[r_wr_ptr] <= w_winner;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ----------------------------------------------------------------- data path
  assign w_rdata = bus.mc_data_i;

  assign bus.req0_data_o       = w_rdata;
  assign bus.req1_data_o       = w_rdata;
  assign bus.req0_data_valid_o = bus.mc_data_valid_i && !w_fifo_empty && !w_head;
  assign bus.req1_data_valid_o = bus.mc_data_valid_i && !w_fifo_empty &&  w_head;
  assign bus.mc_data_ready_o   = !w_fifo_empty &&
                                 (w_head ? bus.req1_data_ready_i : bus.req0_data_ready_i);

  // Data arriving with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (bus.mc_data_valid_i && w_fifo_empty) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sram_req_arbiter                                        |
// | Description : Self-checking bench for sram_req_arbiter: a vector table   |
// |               for the basic flow, hand-written stall / full / head-hold  |
// |               / error / reset sequences and a randomised scoreboard run. |
// | Config      : ARB_FIXED_PRIORITY_EN switches tie expectations            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sram_req_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TD = 4;
`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FX = 1'b1;
`else
  localparam bit FX = 1'b0;
`endif
  localparam bit NF = !FX;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic v0, v1; logic [AW-1:0] a0, a1; logic mrdy, mdv; logic [DW-1:0] md; logic dr0, dr1;
    logic ar0, ar1, mcv; logic [AW-1:0] mca; logic dv0, dv1, mdr, err;
  } vec_t;

  typedef struct { logic own; logic [AW-1:0] addr; } ent_t;
  ent_t aq[$];   // accepted, not yet taken by controller
  ent_t dq[$];   // issued to controller, data not yet returned
  bit   last_w;
  bit   acc0, acc1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v0, logic v1, logic [AW-1:0] a0, logic [AW-1:0] a1,
                              logic mrdy, logic mdv, logic [DW-1:0] md,
                              logic ar0, logic ar1, logic mcv, logic [AW-1:0] mca,
                              logic dv0, logic dv1, logic mdr);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1; v.mrdy = mrdy; v.mdv = mdv; v.md = md;
    v.dr0 = 1'b1; v.dr1 = 1'b1;
    v.ar0 = ar0; v.ar1 = ar1; v.mcv = mcv; v.mca = mca; v.dv0 = dv0; v.dv1 = dv1;
    v.mdr = mdr; v.err = 1'b0;
    return v;
  endfunction

  function automatic logic [DW-1:0] data_of(logic [AW-1:0] a);
    return {a, 8'h5A, a};
  endfunction

  task automatic drive_idle();
    bus.req0_addr_valid_i = 1'b0; bus.req1_addr_valid_i = 1'b0;
    bus.req0_addr_i = '0;         bus.req1_addr_i = '0;
    bus.req0_data_ready_i = 1'b1; bus.req1_data_ready_i = 1'b1;
    bus.mc_addr_ready_i = 1'b0;   bus.mc_data_valid_i = 1'b0;
    bus.mc_data_i = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    aq.delete(); dq.delete();
    last_w = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
  endtask

  // One cycle of randomised traffic checked against a queue-based model.
  task automatic stream_cycle(input bit allow_new);
    int   cnt;
    bit   w, can, e0, e1, own, pend;
    ent_t e;
    cyc();
    if (acc0) bus.req0_addr_valid_i = 1'b0;
    if (acc1) bus.req1_addr_valid_i = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0;
    if (allow_new) begin
      if (!bus.req0_addr_valid_i && $urandom_range(0, 1) == 1) begin
        bus.req0_addr_valid_i = 1'b1; bus.req0_addr_i = AW'($urandom);
      end
      if (!bus.req1_addr_valid_i && $urandom_range(0, 1) == 1) begin
        bus.req1_addr_valid_i = 1'b1; bus.req1_addr_i = AW'($urandom);
      end
      bus.mc_addr_ready_i   = ($urandom_range(0, 3) != 0);
      bus.req0_data_ready_i = ($urandom_range(0, 3) != 0);
      bus.req1_data_ready_i = ($urandom_range(0, 3) != 0);
    end else begin
      bus.mc_addr_ready_i = 1'b1; bus.req0_data_ready_i = 1'b1; bus.req1_data_ready_i = 1'b1;
    end
    pend = (dq.size() > 0) && (!allow_new || $urandom_range(0, 2) != 0);
    bus.mc_data_valid_i = pend;
    bus.mc_data_i       = pend ? data_of(dq[0].addr) : '0;
    smp();
    cnt = aq.size() + dq.size();
    if (bus.req0_addr_valid_i && bus.req1_addr_valid_i) w = FX ? 1'b0 : !last_w;
    else w = !bus.req0_addr_valid_i;
    can = (cnt < TD) && (aq.size() == 0 || bus.mc_addr_ready_i);
    e0  = can && !w && bus.req0_addr_valid_i;
    e1  = can &&  w && bus.req1_addr_valid_i;
    check("sb.ar0", bus.req0_addr_ready_o, e0);
    check("sb.ar1", bus.req1_addr_ready_o, e1);
    check("sb.mcv", bus.mc_addr_valid_o, aq.size() != 0);
    if (pend) begin
      own = dq[0].own;
      check("sb.dv0", bus.req0_data_valid_o, !own);
      check("sb.dv1", bus.req1_data_valid_o, own);
      check("sb.mdr", bus.mc_data_ready_o, own ? bus.req1_data_ready_i : bus.req0_data_ready_i);
      check("sb.data", own ? bus.req1_data_o : bus.req0_data_o, bus.mc_data_i);
      if (own ? bus.req1_data_ready_i : bus.req0_data_ready_i) void'(dq.pop_front());
    end else begin
      check("sb.dv_idle", {bus.req0_data_valid_o, bus.req1_data_valid_o}, 0);
    end
    if (aq.size() != 0 && bus.mc_addr_ready_i) begin
      e = aq.pop_front();
      check("sb.mca", bus.mc_addr_o, e.addr);
      dq.push_back(e);
    end
    if (e0) begin aq.push_back('{own: 1'b0, addr: bus.req0_addr_i}); last_w = 1'b0; acc0 = 1'b1; end
    if (e1) begin aq.push_back('{own: 1'b1, addr: bus.req1_addr_i}); last_w = 1'b1; acc1 = 1'b1; end
  endtask

  vec_t tbl[12];
  int   acc;

  initial begin
    logic [AW-1:0] a6;
    a6 = FX ? 12'h100 : 12'h200;
    //            v0 v1 a0      a1      mrdy mdv md            ar0 ar1 mcv mca     dv0 dv1 mdr
    tbl[0]  = mk(0, 0, 12'h000, 12'h000, 0, 0, 32'h0,        0,  0,  0, 12'h000, 0,  0,  0);
    tbl[1]  = mk(1, 0, 12'h010, 12'h000, 0, 0, 32'h0,        1,  0,  0, 12'h000, 0,  0,  0);
    tbl[2]  = mk(0, 0, 12'h000, 12'h000, 1, 0, 32'h0,        0,  0,  1, 12'h010, 0,  0,  1);
    tbl[3]  = mk(0, 0, 12'h000, 12'h000, 1, 1, 32'hDEADBEEF, 0,  0,  0, 12'h010, 1,  0,  1);
    tbl[4]  = mk(0, 0, 12'h000, 12'h000, 1, 0, 32'h0,        0,  0,  0, 12'h010, 0,  0,  0);
    tbl[5]  = mk(1, 1, 12'h100, 12'h200, 1, 0, 32'h0,        FX, NF, 0, 12'h010, 0,  0,  0);
    tbl[6]  = mk(1, 1, 12'h100, 12'h200, 1, 0, 32'h0,        1,  0,  1, a6,      0,  0,  1);
    tbl[7]  = mk(1, 1, 12'h100, 12'h200, 1, 0, 32'h0,        FX, NF, 1, 12'h100, 0,  0,  1);
    tbl[8]  = mk(0, 0, 12'h000, 12'h000, 1, 1, 32'h11111111, 0,  0,  1, a6,      FX, NF, 1);
    tbl[9]  = mk(0, 0, 12'h000, 12'h000, 1, 1, 32'h22222222, 0,  0,  0, a6,      1,  0,  1);
    tbl[10] = mk(0, 0, 12'h000, 12'h000, 1, 1, 32'h33333333, 0,  0,  0, a6,      FX, NF, 1);
    tbl[11] = mk(0, 0, 12'h000, 12'h000, 1, 0, 32'h0,        0,  0,  0, a6,      0,  0,  0);

    drive_idle();
    repeat (2) @(posedge clk);
    smp();
    check("rst.mcv", bus.mc_addr_valid_o, 0);
    check("rst.mca", bus.mc_addr_o, 0);
    check("rst.mdr", bus.mc_data_ready_o, 0);
    check("rst.err", bus.err_o, 0);
    #1 rst_n = 1'b1;

    // ---------------------------------------------------------- vector table
    for (int i = 0; i < 12; i++) begin
      cyc();
      bus.req0_addr_valid_i = tbl[i].v0;   bus.req1_addr_valid_i = tbl[i].v1;
      bus.req0_addr_i       = tbl[i].a0;   bus.req1_addr_i       = tbl[i].a1;
      bus.mc_addr_ready_i   = tbl[i].mrdy; bus.mc_data_valid_i   = tbl[i].mdv;
      bus.mc_data_i         = tbl[i].md;
      bus.req0_data_ready_i = tbl[i].dr0;  bus.req1_data_ready_i = tbl[i].dr1;
      smp();
      check($sformatf("v%0d.ar0", i), bus.req0_addr_ready_o, tbl[i].ar0);
      check($sformatf("v%0d.ar1", i), bus.req1_addr_ready_o, tbl[i].ar1);
      check($sformatf("v%0d.mcv", i), bus.mc_addr_valid_o,   tbl[i].mcv);
      check($sformatf("v%0d.mca", i), bus.mc_addr_o,         tbl[i].mca);
      check($sformatf("v%0d.dv0", i), bus.req0_data_valid_o, tbl[i].dv0);
      check($sformatf("v%0d.dv1", i), bus.req1_data_valid_o, tbl[i].dv1);
      check($sformatf("v%0d.mdr", i), bus.mc_data_ready_o,   tbl[i].mdr);
      check($sformatf("v%0d.err", i), bus.err_o,             tbl[i].err);
      if (tbl[i].dv0) check($sformatf("v%0d.d0", i), bus.req0_data_o, tbl[i].md);
      if (tbl[i].dv1) check($sformatf("v%0d.d1", i), bus.req1_data_o, tbl[i].md);
    end

    // ------------------------------------------- full FIFO: exactly TD accepts
    do_reset();
    acc = 0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      bus.req0_addr_valid_i = 1'b1; bus.req0_addr_i = AW'(12'h300 + acc);
      bus.mc_addr_ready_i   = 1'b1;
      smp();
      check($sformatf("full.ar0[%0d]", k), bus.req0_addr_ready_o, acc < TD);
      if (bus.req0_addr_ready_o) acc++;
    end
    cyc();
    bus.req1_addr_valid_i = 1'b1; bus.req1_addr_i = 12'h400;
    smp();
    check("full.both", {bus.req0_addr_ready_o, bus.req1_addr_ready_o}, 0);
    cyc();
    bus.mc_data_valid_i = 1'b1; bus.mc_data_i = 32'hCAFE0001;
    smp();
    check("full.pop_mdr", bus.mc_data_ready_o, 1);
    check("full.pop_dv0", bus.req0_data_valid_o, 1);
    check("full.no_bypass", {bus.req0_addr_ready_o, bus.req1_addr_ready_o}, 0);
    cyc();
    bus.mc_data_valid_i = 1'b0;
    smp();
    check("full.reopen", {bus.req0_addr_ready_o, bus.req1_addr_ready_o}, {FX, NF});
    cyc();
    smp();
    check("full.again", {bus.req0_addr_ready_o, bus.req1_addr_ready_o}, 0);

    // ----------------------------------------------- randomised scoreboard run
    do_reset();
    for (int k = 0; k < 400; k++) stream_cycle(1'b1);
    for (int k = 0; k < 40; k++) begin
      if (aq.size() == 0 && dq.size() == 0 && !bus.req0_addr_valid_i && !bus.req1_addr_valid_i
          && !acc0 && !acc1) break;
      stream_cycle(1'b0);
      if (acc0) bus.req0_addr_valid_i = 1'b0;
      if (acc1) bus.req1_addr_valid_i = 1'b0;
    end
    n_vec++;
    if (aq.size() != 0 || dq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d addr / %0d data still outstanding, expected 0", aq.size(), dq.size());
    end

    // ------------------------------ stall, head hold, empty-FIFO data, reset
    do_reset();
    cyc();
    bus.req0_addr_valid_i = 1'b1; bus.req0_addr_i = 12'h055;
    smp();
    check("stall.acc0", bus.req0_addr_ready_o, 1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      bus.req0_addr_valid_i = 1'b0;
      bus.req1_addr_valid_i = 1'b1; bus.req1_addr_i = 12'h0AA;
      smp();
      check($sformatf("stall.mcv[%0d]", k), bus.mc_addr_valid_o, 1);
      check($sformatf("stall.mca[%0d]", k), bus.mc_addr_o, 12'h055);
      check($sformatf("stall.ar1[%0d]", k), bus.req1_addr_ready_o, 0);
    end
    cyc();
    bus.mc_addr_ready_i = 1'b1;
    smp();
    check("stall.release_ar1", bus.req1_addr_ready_o, 1);
    cyc();
    bus.req1_addr_valid_i = 1'b0;
    smp();
    check("stall.next_mca", bus.mc_addr_o, 12'h0AA);
    check("stall.next_mcv", bus.mc_addr_valid_o, 1);
    cyc();
    bus.mc_addr_ready_i = 1'b0;
    bus.mc_data_valid_i = 1'b1; bus.mc_data_i = 32'hA5A5A5A5; bus.req1_data_ready_i = 1'b0;
    smp();
    check("head0.dv0", bus.req0_data_valid_o, 1);
    check("head0.mdr", bus.mc_data_ready_o, 1);
    check("head0.mcv", bus.mc_addr_valid_o, 0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      bus.mc_data_i = 32'h5A5A5A5A;
      smp();
      check($sformatf("hold.dv1[%0d]", k), bus.req1_data_valid_o, 1);
      check($sformatf("hold.dv0[%0d]", k), bus.req0_data_valid_o, 0);
      check($sformatf("hold.mdr[%0d]", k), bus.mc_data_ready_o, 0);
    end
    cyc();
    bus.req1_data_ready_i = 1'b1;
    smp();
    check("head1.mdr", bus.mc_data_ready_o, 1);
    check("head1.data", bus.req1_data_o, 32'h5A5A5A5A);
    cyc();
    smp();
    check("empty.mdr", bus.mc_data_ready_o, 0);
    check("empty.dv", {bus.req0_data_valid_o, bus.req1_data_valid_o}, 0);
    check("empty.err_pre", bus.err_o, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      bus.mc_data_valid_i = 1'b0;
      smp();
      check($sformatf("err.sticky[%0d]", k), bus.err_o, 1);
    end
    cyc();
    rst_n = 1'b0;
    #1;
    check("err.cleared", bus.err_o, 0);
    #1 rst_n = 1'b1;

    // ----------------------------------------- reset in the middle of a read
    do_reset();
    cyc();
    bus.req0_addr_valid_i = 1'b1; bus.req0_addr_i = 12'h077;
    smp();
    check("mid.acc0", bus.req0_addr_ready_o, 1);
    cyc();
    bus.req0_addr_valid_i = 1'b0;
    check("mid.pre_mcv", bus.mc_addr_valid_o, 1);
    rst_n = 1'b0;
    #2;
    check("mid.mcv", bus.mc_addr_valid_o, 0);
    check("mid.mca", bus.mc_addr_o, 0);
    cyc();
    rst_n = 1'b1;
    bus.mc_data_valid_i = 1'b1; bus.mc_data_i = 32'h12345678;
    smp();
    check("mid.fifo_clr", bus.mc_data_ready_o, 0);
    check("mid.dv0", bus.req0_data_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-requester arbiter that shares one SRAM memory-controller port (single- or multi-SRAM controller) between two independent address/data masters. It accepts read addresses from both masters, serialises them onto the controller's address channel, and records the grantee of each in a tag FIFO. Read data returns in issue order and is steered back to the owning master. It sits between the driver-side masters and the controller.

## Interface
- ADDR_WIDTH, 12, address width of all address channels
- DATA_WIDTH, 32, data width of all data channels
- TAG_DEPTH, 4, maximum outstanding reads; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req0_addr_valid_i / req1_addr_valid_i  in  1  master address valid
- req0_addr_ready_o / req1_addr_ready_o  out  1  master address accepted
- req0_addr_i / req1_addr_i  in  ADDR_WIDTH  master read address
- req0_data_valid_o / req1_data_valid_o  out  1  read data valid to master
- req0_data_ready_i / req1_data_ready_i  in  1  master can take data
- req0_data_o / req1_data_o  out  DATA_WIDTH  read data (both driven from mc_data_i)
- mc_addr_valid_o  out  1  address valid to controller
- mc_addr_ready_i  in  1  controller accepts address
- mc_addr_o  out  ADDR_WIDTH  registered address to controller
- mc_data_valid_i  in  1  controller data valid
- mc_data_ready_o  out  1  arbiter/master accepts controller data
- mc_data_i  in  DATA_WIDTH  controller read data
- err_o  out  1  sticky protocol error

## Operation
- States: IDLE (output register empty), ISSUE (mc_addr_valid_o=1, mc_addr_o holds an address).
- can_accept = !fifo_full && (state==IDLE || mc_addr_ready_i).
- Winner: only one valid → that port; both valid → round-robin, port ≠ last_grant. reqN_addr_ready_o = can_accept && winner==N && reqN_addr_valid_i (combinational).
- On upstream handshake: mc_addr_o ← winner address, push winner id to tag FIFO, last_grant ← winner, state → ISSUE.
- ISSUE with mc_addr_ready_i and no accept → IDLE; with accept → stay ISSUE (back-to-back, 1 address/cycle).
- mc_addr_o and mc_addr_valid_o stable while mc_addr_ready_i=0.
- Data return: head = FIFO head tag. reqN_data_valid_o = mc_data_valid_i && !fifo_empty && head==N. mc_data_ready_o = !fifo_empty && req[head]_data_ready_i. Pop on mc_data_valid_i && mc_data_ready_o.
- FIFO count = addresses accepted but data not returned; range 0..TAG_DEPTH; pointers wrap modulo TAG_DEPTH.
- mc_data_valid_i=1 with FIFO empty: data dropped (mc_data_ready_o=0), err_o ← 1 until reset.

## Timing
- Reset values: state IDLE, FIFO empty, last_grant=1 (port 0 wins first tie), mc_addr_o=0, mc_addr_valid_o=0, err_o=0; all ready/valid outputs 0 (combinational ones are 0 because FIFO/inputs yield 0; reqN_addr_ready_o may rise in first cycle after release).
- Address latency: master handshake in cycle t → mc_addr_valid_o=1 in t+1.
- Data path zero-latency combinational passthrough; no data registering.
- Full: accept blocked when count==TAG_DEPTH at cycle start; a same-cycle pop does not bypass-free a slot.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Reset asserted mid-transaction: all state cleared immediately; in-flight addresses/tags discarded.

## Configuration
- ARB_FIXED_PRIORITY_EN defined: port 0 always wins when both valid; last_grant unused. Undefined (default): round-robin as above.

## Test plan
- Reset then req0 valid addr 0x010 only → req0_addr_ready_o=1 same cycle, mc_addr_valid_o=1/mc_addr_o=0x010 next cycle; data 0xDEADBEEF returns → req0_data_valid_o=1, req1_data_valid_o=0.
- Both valid continuously, mc ready=1, addrs 0x100/0x200 → grants alternate 0,1,0,1; returned data routed in same order; with ARB_FIXED_PRIORITY_EN only port 0 granted.
- mc_addr_ready_i=0 for 5 cycles in ISSUE → mc_addr_o constant, no further upstream accept; released → issue resumes next edge.
- TAG_DEPTH=4, no data returned → exactly 4 accepts, then both addr_ready=0; one data return → one more accept the following cycle.
- Head tag=1 with req1_data_ready_i=0 → mc_data_ready_o=0, FIFO holds; ready=1 → pop.
- mc_data_valid_i=1 with empty FIFO → mc_data_ready_o=0, err_o=1 and stays until rst_n low.
